// File: rtl/neural_soc_sysid_pkg.sv
// Shared constants for the system-ID peripheral: word addresses, CONTROL bit layout, byte-lane merge.
package neural_soc_sysid_pkg;

  typedef logic [31:0] word_t;

  localparam word_t ADDR_ID        = 32'd0;
  localparam word_t ADDR_TIMESTAMP = 32'd1;
  localparam word_t ADDR_VERSION   = 32'd2;
  localparam word_t ADDR_SCRATCH   = 32'd3;
  localparam word_t ADDR_UPTIME_LO = 32'd4;
  localparam word_t ADDR_UPTIME_HI = 32'd5;
  localparam word_t ADDR_CONTROL   = 32'd6;

  localparam int unsigned CTRL_RUN     = 0;
  localparam int unsigned CTRL_CLR     = 1;
  localparam logic        CTRL_RUN_RST = 1'b1;

  function automatic word_t be_merge(input word_t old_w, input word_t new_w, input logic [3:0] be);
    word_t r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/neural_soc_sysid_ext_if.sv
// Avalon-MM style control-bus bundle between a bus master and the system-ID peripheral.
interface neural_soc_sysid_ext_if #(
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/neural_soc_sysid_uptime.sv
// Prescaled free-running uptime counter; CLR beats a coincident tick, counting gated by RUN.
module neural_soc_sysid_uptime #(
  parameter int UPTIME_W = 48,
  parameter int TICK_DIV = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                run,
  input  logic                clr,
  output logic [UPTIME_W-1:0] count
);
  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PS_W-1:0] presc;
  logic            tick;

  assign tick = run && (presc == PS_W'(TICK_DIV - 1));

  always_ff @(posedge clock) begin
    if (!reset_n || clr) begin
      presc <= '0;
      count <= '0;
    end else if (run) begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/neural_soc_sysid_ext.sv
// System-ID peripheral: ID/timestamp/version/scratch, plus uptime counter when NEURAL_SOC_SYSID_UPTIME_EN is defined.
// Reads return one cycle later with readdatavalid; no wait states.
module neural_soc_sysid_ext
  import neural_soc_sysid_pkg::*;
#(
  parameter logic [31:0] ID_VALUE  = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP = 32'd1480977927,
  parameter logic [31:0] VERSION   = 32'h0001_0000,
  parameter int          ADDR_W    = 3,
  parameter int          UPTIME_W  = 48,
  parameter int          TICK_DIV  = 1
) (
  input logic                  clock,
  input logic                  reset_n,
  neural_soc_sysid_ext_if.slave bus
);
  logic [ADDR_W-1:0] word_addr;
  word_t             addr;
  word_t             scratch;
  word_t             rd_word;
  word_t             up_lo;
  word_t             up_hi;
  word_t             ctrl_word;

  // Full-width compare so addresses >= 8 never alias onto the map.
  assign word_addr = bus.address;
  assign addr      = 32'(word_addr);

`ifdef NEURAL_SOC_SYSID_UPTIME_EN
  logic                run;
  logic                wr_ctrl;
  logic                clr;
  logic [UPTIME_W-1:0] count;
  logic [63:0]         count64;
  word_t               snap_hi;

  assign wr_ctrl = bus.write && (addr == ADDR_CONTROL);
  assign clr     = wr_ctrl && bus.writedata[CTRL_CLR];

  always_ff @(posedge clock) begin
    if (!reset_n)     run <= CTRL_RUN_RST;
    else if (wr_ctrl) run <= bus.writedata[CTRL_RUN];
  end

  neural_soc_sysid_uptime #(
    .UPTIME_W (UPTIME_W),
    .TICK_DIV (TICK_DIV)
  ) u_uptime (
    .clock   (clock),
    .reset_n (reset_n),
    .run     (run),
    .clr     (clr),
    .count   (count)
  );

  // Zero-extension makes narrow counters read HI=0 and a zero-padded LO.
  assign count64 = 64'(count);

  always_ff @(posedge clock) begin
    if (!reset_n)                                  snap_hi <= '0;
    else if (bus.read && addr == ADDR_UPTIME_LO)   snap_hi <= count64[63:32];
  end

  assign up_lo     = count64[31:0];
  assign up_hi     = snap_hi;
  assign ctrl_word = {31'b0, run};
`else
  assign up_lo     = '0;
  assign up_hi     = '0;
  assign ctrl_word = '0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n)                               scratch <= '0;
    else if (bus.write && addr == ADDR_SCRATCH) scratch <= be_merge(scratch, bus.writedata, bus.byteenable);
  end

  always_comb begin
    rd_word = '0;
    case (addr)
      ADDR_ID:        rd_word = ID_VALUE;
      ADDR_TIMESTAMP: rd_word = TIMESTAMP;
      ADDR_VERSION:   rd_word = VERSION;
      ADDR_SCRATCH:   rd_word = scratch;
      ADDR_UPTIME_LO: rd_word = up_lo;
      ADDR_UPTIME_HI: rd_word = up_hi;
      ADDR_CONTROL:   rd_word = ctrl_word;
      default:        rd_word = '0;
    endcase
  end

  // rd_word reflects pre-edge state, so a same-cycle write is not seen by the read.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bus.readdata      <= '0;
      bus.readdatavalid <= 1'b0;
    end else begin
      bus.readdatavalid <= bus.read;
      if (bus.read) bus.readdata <= rd_word;
    end
  end
endmodule

// File: tb/tb_neural_soc_sysid_ext.sv
// Directed bench for neural_soc_sysid_ext; uptime scenarios compiled only with NEURAL_SOC_SYSID_UPTIME_EN.
module tb_neural_soc_sysid_ext;
  localparam logic [31:0] ID_V  = 32'hA5A5_0001;
  localparam logic [31:0] TS_V  = 32'd1480977927;
  localparam logic [31:0] VER_V = 32'h0001_0000;
`ifdef NEURAL_SOC_SYSID_UPTIME_EN
  localparam bit UP_EN = 1'b1;
`else
  localparam bit UP_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  neural_soc_sysid_ext_if #(.ADDR_W(4)) bus ();

  neural_soc_sysid_ext #(
    .ID_VALUE  (ID_V),
    .TIMESTAMP (TS_V),
    .VERSION   (VER_V),
    .ADDR_W    (4),
    .UPTIME_W  (48),
    .TICK_DIV  (4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.address = a; bus.writedata = d; bus.byteenable = be; bus.write = 1'b1;
    @(negedge clock);
    bus.write = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic v);
    bus.address = a; bus.read = 1'b1;
    @(negedge clock);
    bus.read = 1'b0;
    d = bus.readdata; v = bus.readdatavalid;
  endtask

  task automatic do_rw(input logic [3:0] a, input logic [31:0] wd, output logic [31:0] d, output logic v);
    bus.address = a; bus.writedata = wd; bus.byteenable = 4'hF;
    bus.read = 1'b1; bus.write = 1'b1;
    @(negedge clock);
    bus.read = 1'b0; bus.write = 1'b0;
    d = bus.readdata; v = bus.readdatavalid;
  endtask

  task automatic test_reset();
    logic [31:0] exp_tab [8];
    logic [31:0] d;
    logic v;
    exp_tab = '{ID_V, TS_V, VER_V, 32'h0, (UP_EN ? 32'd1 : 32'd0), 32'h0, (UP_EN ? 32'd1 : 32'd0), 32'h0};
    n_checks++;
    if (bus.readdata !== 32'h0 || bus.readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs got data=%h vld=%b want 0/0", bus.readdata, bus.readdatavalid);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      do_read(4'(i), d, v);
      n_checks++;
      if (v !== 1'b1 || d !== exp_tab[i]) begin
        n_fail++; $display("FAIL reset_read_a%0d got data=%h vld=%b want %h/1", i, d, v, exp_tab[i]);
      end
    end
  endtask

  task automatic test_scratch();
    logic [31:0] d;
    logic v;
    logic [31:0] wd_tab [3];
    logic [3:0]  be_tab [3];
    logic [31:0] exp_tab [3];
    wd_tab  = '{32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF};
    be_tab  = '{4'b0101, 4'b1010, 4'b0000};
    exp_tab = '{32'h00AD00EF, 32'h12AD56EF, 32'h12AD56EF};
    for (int i = 0; i < 3; i++) begin
      do_write(4'd3, wd_tab[i], be_tab[i]);
      do_read(4'd3, d, v);
      n_checks++;
      if (d !== exp_tab[i]) begin
        n_fail++; $display("FAIL scratch_be_%0d got %h want %h", i, d, exp_tab[i]);
      end
    end
  endtask

  task automatic test_rw_same();
    logic [31:0] d;
    logic v;
    do_write(4'd3, 32'h1, 4'hF);
    do_rw(4'd3, 32'h2, d, v);
    n_checks++;
    if (v !== 1'b1 || d !== 32'h1) begin
      n_fail++; $display("FAIL rw_same_old got %h vld=%b want 00000001/1", d, v);
    end
    do_read(4'd3, d, v);
    n_checks++;
    if (d !== 32'h2) begin
      n_fail++; $display("FAIL rw_same_new got %h want 00000002", d);
    end
  endtask

  task automatic test_ro_and_unmapped();
    logic [31:0] d;
    logic v;
    do_write(4'd0, 32'hFFFFFFFF, 4'hF);
    do_write(4'd2, 32'h0BAD0BAD, 4'hF);
    do_write(4'd11, 32'h55, 4'hF);
    do_write(4'd14, 32'h0, 4'hF);
    do_write(4'd7, 32'h77, 4'hF);
    do_read(4'd0, d, v);
    n_checks++;
    if (d !== ID_V) begin n_fail++; $display("FAIL ro_id got %h want %h", d, ID_V); end
    do_read(4'd2, d, v);
    n_checks++;
    if (d !== VER_V) begin n_fail++; $display("FAIL ro_version got %h want %h", d, VER_V); end
    do_read(4'd3, d, v);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL alias_scratch got %h want 00000002", d); end
    do_read(4'd11, d, v);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL addr11 got %h want 0", d); end
    do_read(4'd6, d, v);
    n_checks++;
    if (d !== (UP_EN ? 32'h1 : 32'h0)) begin n_fail++; $display("FAIL alias_control got %h", d); end
    do_read(4'd7, d, v);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL addr7 got %h want 0", d); end
    do_read(4'd1, d, v);
    @(negedge clock);
    n_checks++;
    if (bus.readdatavalid !== 1'b0 || bus.readdata !== TS_V) begin
      n_fail++; $display("FAIL idle_hold got data=%h vld=%b want %h/0", bus.readdata, bus.readdatavalid, TS_V);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d;
    logic v;
    bus.address = 4'd0; bus.read = 1'b1; reset_n = 1'b0;
    @(negedge clock);
    bus.read = 1'b0;
    n_checks++;
    if (bus.readdatavalid !== 1'b0 || bus.readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_read got data=%h vld=%b want 0/0", bus.readdata, bus.readdatavalid);
    end
    @(negedge clock);
    reset_n = 1'b1;
    do_read(4'd3, d, v);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL scratch_after_reset got %h want 0", d); end
  endtask

`ifdef NEURAL_SOC_SYSID_UPTIME_EN
  task automatic test_run_clr();
    logic [31:0] d;
    logic v;
    do_write(4'd6, 32'h3, 4'hF);
    repeat (40) @(negedge clock);
    do_write(4'd6, 32'h0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      do_read(4'd4, d, v);
      n_checks++;
      if (d !== 32'd10) begin n_fail++; $display("FAIL frozen_lo_%0d got %0d want 10", i, d); end
    end
    do_read(4'd6, d, v);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL control_off got %h want 0", d); end
    do_write(4'd6, 32'h3, 4'hF);
    do_read(4'd4, d, v);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL clr_lo got %0d want 0", d); end
    repeat (8) @(negedge clock);
    do_read(4'd4, d, v);
    n_checks++;
    if (d !== 32'd2) begin n_fail++; $display("FAIL resume_lo got %0d want 2", d); end
    @(negedge clock);
    do_write(4'd6, 32'h3, 4'hF);
    do_read(4'd4, d, v);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL clr_on_tick got %0d want 0", d); end
    do_write(4'd6, 32'h2, 4'hF);
    repeat (10) @(negedge clock);
    do_read(4'd4, d, v);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL clr_run_off got %0d want 0", d); end
    do_read(4'd6, d, v);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL control_clr_reads0 got %h want 0", d); end
    do_write(4'd6, 32'h1, 4'hF);
  endtask

  task automatic test_snapshot();
    logic [31:0] d;
    logic v;
    force dut.u_uptime.count = 48'h0000_FFFF_FFFF;
    bus.address = 4'd4; bus.read = 1'b1;
    @(negedge clock);
    bus.read = 1'b0;
    release dut.u_uptime.count;
    n_checks++;
    if (bus.readdata !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL snap_lo got %h want ffffffff", bus.readdata);
    end
    do_read(4'd5, d, v);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL snap_hi got %h want 0", d); end
    repeat (8) @(negedge clock);
    do_read(4'd4, d, v);
    do_read(4'd5, d, v);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL snap_hi_live got %h want 1", d); end
  endtask
`else
  task automatic test_uptime_disabled();
    logic [31:0] d;
    logic v;
    repeat (1000) @(negedge clock);
    for (int i = 4; i < 7; i++) begin
      do_read(4'(i), d, v);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL disabled_a%0d got %h want 0", i, d); end
    end
    do_write(4'd6, 32'h3, 4'hF);
    do_read(4'd6, d, v);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL disabled_ctrl_write got %h want 0", d); end
  endtask
`endif

  task automatic test_back_to_back();
    logic [31:0] d;
    logic v;
    logic [3:0]  a_tab [4];
    logic [31:0] exp_tab [4];
    a_tab   = '{4'd0, 4'd1, 4'd2, 4'd0};
    exp_tab = '{ID_V, TS_V, VER_V, ID_V};
    for (int i = 0; i < 4; i++) begin
      do_read(a_tab[i], d, v);
      n_checks++;
      if (v !== 1'b1 || d !== exp_tab[i]) begin
        n_fail++; $display("FAIL b2b_%0d got data=%h vld=%b want %h/1", i, d, v, exp_tab[i]);
      end
    end
  endtask

  initial begin
    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0;
    bus.writedata = '0; bus.byteenable = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    test_reset();
    test_scratch();
    test_rw_same();
    test_ro_and_unmapped();
    test_back_to_back();
`ifdef NEURAL_SOC_SYSID_UPTIME_EN
    test_run_clr();
    test_snapshot();
`else
    test_uptime_disabled();
`endif
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
